// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide, HI/LO result.
// Optional macro MULDIV_EARLY_EXIT_EN lets a multiply leave RUN once the multiplier is exhausted.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_r, b_r, opnd, mpl;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, is_sgn, neg_res, neg_rem, dz_pend;
    logic               accept;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    assign busy   = (state != IDLE) || done;
    assign accept = (state == IDLE) && !done && start && (control[3:2] == 2'b11);

    // Per-cycle arithmetic: one multiplier bit or one quotient bit per RUN cycle
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mpl[0] ? opnd : '0)};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

`ifdef MULDIV_EARLY_EXIT_EN
    // Skipped iterations only shift, so align by the remaining count in one step.
    assign prod = acc >> cnt;
`else
    assign prod = acc;
`endif
    assign prod_fix = cond_neg2(prod, neg_res);
    assign quo_fix  = cond_neg(acc[WIDTH-1:0], neg_res);
    assign rem_fix  = cond_neg(acc[2*WIDTH-1:WIDTH], neg_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = PREP;
            PREP: state_nxt = (is_div && (b_r == '0)) ? FIX : RUN;
            RUN: begin
                if (cnt == CNT_W'(1)) state_nxt = FIX;
`ifdef MULDIV_EARLY_EXIT_EN
                else if (!is_div && (mpl[WIDTH-1:1] == '0)) state_nxt = FIX;
`endif
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; b_r <= '0; opnd <= '0; mpl <= '0; acc <= '0; cnt <= '0;
            is_div <= 1'b0; is_sgn <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0; dz_pend <= 1'b0;
            done <= 1'b0; hi <= '0; lo <= '0; dz <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    a_r    <= in1;
                    b_r    <= in2;
                    is_div <= control[0];
                    is_sgn <= control[1];
                end
                // Magnitudes and result signs; the core loops are unsigned
                PREP: begin
                    neg_res <= is_sgn && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_rem <= is_sgn && a_r[WIDTH-1];
                    opnd    <= is_div ? mag(b_r, is_sgn) : mag(a_r, is_sgn);
                    mpl     <= mag(b_r, is_sgn);
                    acc     <= is_div ? {{WIDTH{1'b0}}, mag(a_r, is_sgn)} : '0;
                    cnt     <= CNT_W'(WIDTH);
                    dz_pend <= is_div && (b_r == '0);
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div)
                        acc <= {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                                acc[WIDTH-2:0], ~div_diff[WIDTH]};
                    else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        mpl <= mpl >> 1;
                    end
                end
                // Sign correction and result write-back
                FIX: begin
                    done <= 1'b1;
                    dz   <= dz_pend;
                    if (dz_pend) begin
                        lo <= '1;
                        hi <= a_r;
                    end else if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod_fix[WIDTH-1:0];
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, handshake, reset and bad-control cases.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   control = 4'b0000;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
    );

    always #5 clk = ~clk;

    // Issue one op; lat = edges after E0 at which done is first seen (-1 on timeout)
    task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject, output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; control = ctl; in1 = a; in2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in1 = ~a; in2 = b ^ 32'h5A5A5A5A; control = 4'b0000;
        if (!busy) busy_ok = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (inject && k == 4) begin
                start = 1'b1; control = 4'b1101; in1 = 32'h0000FFFF; in2 = 32'h00000003;
            end
            if (k == 5) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (hi !== '0)     begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        if (lo !== '0)     begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        if (dz !== 1'b0)   begin n_fail++; $display("FAIL reset_dz: got %b expected 0", dz); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_unsigned();
        int lat; bit bok;
        run_op(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bok);
        n_chk += 5;
        if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulu_max_hi: got %h expected FFFFFFFE", hi); end
        if (lo !== 32'h00000001) begin n_fail++; $display("FAIL mulu_max_lo: got %h expected 00000001", lo); end
        if (dz !== 1'b0)         begin n_fail++; $display("FAIL mulu_max_dz: got %b expected 0", dz); end
        if (lat !== 34)          begin n_fail++; $display("FAIL mulu_latency: got %0d expected 34", lat); end
        if (!bok)                begin n_fail++; $display("FAIL mulu_busy_hold: got dropout expected steady high"); end
        @(negedge clk);
        n_chk += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL mulu_done_pulse: got %b expected 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mulu_busy_drop: got %b expected 0", busy); end
        run_op(4'b1100, 32'h00000055, 32'h00000002, 1'b0, lat, bok);
        n_chk += 2;
        if (hi !== 32'h0)        begin n_fail++; $display("FAIL mulu_small_hi: got %h expected 00000000", hi); end
        if (lo !== 32'h000000AA) begin n_fail++; $display("FAIL mulu_small_lo: got %h expected 000000AA", lo); end
    endtask

    task automatic test_mul_signed();
        int lat; bit bok;
        run_op(4'b1110, 32'hFFFFFFFA, 32'h00000007, 1'b0, lat, bok);
        n_chk += 2;
        if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL muls_neg_a_hi: got %h expected FFFFFFFF", hi); end
        if (lo !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL muls_neg_a_lo: got %h expected FFFFFFD6", lo); end
        run_op(4'b1110, 32'hFFFFFFFA, 32'hFFFFFFF9, 1'b0, lat, bok);
        n_chk += 2;
        if (hi !== 32'h0)        begin n_fail++; $display("FAIL muls_neg_both_hi: got %h expected 00000000", hi); end
        if (lo !== 32'h0000002A) begin n_fail++; $display("FAIL muls_neg_both_lo: got %h expected 0000002A", lo); end
    endtask

    task automatic test_div_signed();
        int lat; bit bok;
        run_op(4'b1111, 32'hFFFFFFF9, 32'h00000002, 1'b0, lat, bok);
        n_chk += 2;
        if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL divs_q: got %h expected FFFFFFFD", lo); end
        if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divs_r: got %h expected FFFFFFFF", hi); end
        run_op(4'b1111, 32'h00000007, 32'hFFFFFFFE, 1'b0, lat, bok);
        n_chk += 2;
        if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL divs_negdiv_q: got %h expected FFFFFFFD", lo); end
        if (hi !== 32'h00000001) begin n_fail++; $display("FAIL divs_negdiv_r: got %h expected 00000001", hi); end
        run_op(4'b1111, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bok);
        n_chk += 3;
        if (lo !== 32'h80000000) begin n_fail++; $display("FAIL divs_ovf_q: got %h expected 80000000", lo); end
        if (hi !== 32'h00000000) begin n_fail++; $display("FAIL divs_ovf_r: got %h expected 00000000", hi); end
        if (dz !== 1'b0)         begin n_fail++; $display("FAIL divs_ovf_dz: got %b expected 0", dz); end
    endtask

    task automatic test_div_zero();
        int lat; bit bok;
        run_op(4'b1101, 32'h00000064, 32'h00000000, 1'b0, lat, bok);
        n_chk += 4;
        if (lat !== 2)           begin n_fail++; $display("FAIL divz_latency: got %0d expected 2", lat); end
        if (dz !== 1'b1)         begin n_fail++; $display("FAIL divz_dz: got %b expected 1", dz); end
        if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_lo: got %h expected FFFFFFFF", lo); end
        if (hi !== 32'h00000064) begin n_fail++; $display("FAIL divz_hi: got %h expected 00000064", hi); end
        run_op(4'b1101, 32'h00000064, 32'h00000007, 1'b0, lat, bok);
        n_chk += 4;
        if (lo !== 32'h0000000E) begin n_fail++; $display("FAIL divu_q: got %h expected 0000000E", lo); end
        if (hi !== 32'h00000002) begin n_fail++; $display("FAIL divu_r: got %h expected 00000002", hi); end
        if (dz !== 1'b0)         begin n_fail++; $display("FAIL divu_dz_clear: got %b expected 0", dz); end
        if (lat !== 34)          begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        run_op(4'b1100, 32'h00001234, 32'h00000010, 1'b1, lat, bok);
        n_chk += 3;
        if (lo !== 32'h00012340) begin n_fail++; $display("FAIL b2b_lo: got %h expected 00012340", lo); end
        if (hi !== 32'h0)        begin n_fail++; $display("FAIL b2b_hi: got %h expected 00000000", hi); end
        if (!bok)                begin n_fail++; $display("FAIL b2b_busy_hold: got dropout expected steady high"); end
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_second_op: got busy %b expected 0", busy); end
    endtask

    task automatic test_bad_control();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1; control = 4'b0010; in1 = 32'h11111111; in2 = 32'h22222222;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        start = 1'b0;
        n_chk += 2;
        if (seen)          begin n_fail++; $display("FAIL badctl_busy: got busy/done asserted expected idle"); end
        if (lo !== 32'h00012340) begin n_fail++; $display("FAIL badctl_lo_hold: got %h expected 00012340", lo); end
    endtask

    task automatic test_reset_mid_op();
        int lat; bit bok; bit seen;
        run_op(4'b1101, 32'h00000064, 32'h00000000, 1'b0, lat, bok);
        @(negedge clk);
        start = 1'b1; control = 4'b1110; in1 = 32'hFFFFFFFA; in2 = 32'h00000007;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (hi !== '0)     begin n_fail++; $display("FAIL rstmid_hi: got %h expected 0", hi); end
        if (lo !== '0)     begin n_fail++; $display("FAIL rstmid_lo: got %h expected 0", lo); end
        if (dz !== 1'b0)   begin n_fail++; $display("FAIL rstmid_dz: got %b expected 0", dz); end
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL rstmid_no_done: got activity expected none"); end
        run_op(4'b1100, 32'h00000055, 32'h00000002, 1'b0, lat, bok);
        n_chk += 2;
        if (lo !== 32'h000000AA) begin n_fail++; $display("FAIL rstmid_after_lo: got %h expected 000000AA", lo); end
        if (lat !== 34 && lat < 3) begin n_fail++; $display("FAIL rstmid_after_lat: got %0d expected completion", lat); end
    endtask

    task automatic test_early_exit();
        int lat; bit bok;
        run_op(4'b1100, 32'h12345678, 32'h00000001, 1'b0, lat, bok);
        n_chk += 3;
        if (hi !== 32'h0)        begin n_fail++; $display("FAIL early_hi: got %h expected 00000000", hi); end
        if (lo !== 32'h12345678) begin n_fail++; $display("FAIL early_lo: got %h expected 12345678", lo); end
`ifdef MULDIV_EARLY_EXIT_EN
        if (lat !== 3)  begin n_fail++; $display("FAIL early_latency: got %0d expected 3", lat); end
`else
        if (lat !== 34) begin n_fail++; $display("FAIL early_latency: got %0d expected 34", lat); end
`endif
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div_signed();
        test_div_zero();
        test_back_to_back();
        test_bad_control();
        test_reset_mid_op();
        test_early_exit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
